// File: rtl/sid_note_sequencer.sv
// sid_note_sequencer
// Buffers host-written note entries in a small FIFO and plays them back on a
// prescaled tick. It drives sid_top's voice inputs and owns the GATE bit
// (waveform[0]) so ADSR attack/release land on note boundaries.
module sid_note_sequencer #(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [47:0]            wr_data,
  input  logic [7:0]             cfg_attack,
  input  logic [7:0]             cfg_sustain,
  input  logic                   enable,
  output logic [15:0]            frequency,
  output logic [7:0]             duration,
  output logic [7:0]             attack,
  output logic [7:0]             sustain,
  output logic [7:0]             waveform,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, GATE_ON, GATE_OFF, GAP} state_t;

  state_t        state;
  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          tick;
  logic [47:0]   head;
  logic          unused_wave0;
  logic [PW-1:0] prescaler;
  logic [8:0]    tick_cnt;
  logic [8:0]    tick_next;
  logic [8:0]    note_ticks;
  logic [7:0]    gate_ticks;

  // A push is refused whenever the FIFO is full, even if a pop frees a slot
  // in the same cycle; this keeps wr_ready a pure function of the count.
  assign wr_ready  = (fifo_count != FULL_COUNT);
  assign push      = wr_valid && wr_ready;
  assign pop       = ((state == IDLE) || (state == GAP)) && enable && (fifo_count != '0);
  assign head      = mem[rd_ptr];
  assign tick      = (prescaler == PRE_LAST);
  assign tick_next = tick_cnt + 9'd1;

  // The host's wave[0] is deliberately discarded: GATE belongs to the sequencer.
  assign unused_wave0 = head[24];

  // Entry storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Playback FSM: times gate and note lengths in ticks, inserts a one-clock
  // gate-low GAP between notes so back-to-back notes always retrigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frequency  <= '0;
      duration   <= '0;
      attack     <= '0;
      sustain    <= '0;
      waveform   <= '0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      prescaler  <= '0;
      tick_cnt   <= '0;
      note_ticks <= '0;
      gate_ticks <= '0;
    end else begin
      underrun <= 1'b0;
      case (state)
        GATE_ON: begin
          prescaler <= tick ? '0 : prescaler + PW'(1);
          if (tick) begin
            tick_cnt <= tick_next;
            // Whichever of gate length or note length is reached first ends the gate.
            if ((tick_next == {1'b0, gate_ticks}) || (tick_next == note_ticks)) begin
              waveform[0] <= 1'b0;
              state       <= (tick_next == note_ticks) ? GAP : GATE_OFF;
            end
          end
        end
        GATE_OFF: begin
          prescaler <= tick ? '0 : prescaler + PW'(1);
          if (tick) begin
            tick_cnt <= tick_next;
            if (tick_next == note_ticks) state <= GAP;
          end
        end
        GAP: begin
          state    <= IDLE;
          busy     <= 1'b0;
          underrun <= enable && (fifo_count == '0);
        end
        default: ;
      endcase
      // Loading a note overrides whatever IDLE or GAP decided above.
      if (pop) begin
        frequency  <= head[47:32];
        duration   <= head[23:16];
        attack     <= cfg_attack;
        sustain    <= cfg_sustain;
        waveform   <= {head[31:25], (head[7:0] != 8'd0)};
        busy       <= 1'b1;
        prescaler  <= '0;
        tick_cnt   <= '0;
        note_ticks <= (head[15:8] == 8'd0) ? 9'd256 : {1'b0, head[15:8]};
        gate_ticks <= head[7:0];
        state      <= (head[7:0] != 8'd0) ? GATE_ON : GATE_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sid_note_sequencer.sv
// tb_sid_note_sequencer
// Directed stimulus against sid_note_sequencer with TICK_DIV=4, DEPTH=8.
// A note-level model (queue of entries plus a clock count since load) predicts
// every output each cycle; literal expectations pin the key timings.
module tb_sid_note_sequencer;

  localparam int TD    = 4;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [47:0] wr_data;
  logic [7:0]  cfg_attack;
  logic [7:0]  cfg_sustain;
  logic        enable;
  logic [15:0] frequency;
  logic [7:0]  duration;
  logic [7:0]  attack;
  logic [7:0]  sustain;
  logic [7:0]  waveform;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        underrun;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  sid_note_sequencer #(.TICK_DIV(TD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .cfg_attack(cfg_attack), .cfg_sustain(cfg_sustain),
    .enable(enable), .frequency(frequency), .duration(duration),
    .attack(attack), .sustain(sustain), .waveform(waveform), .busy(busy),
    .fifo_count(fifo_count), .underrun(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [47:0] mkNote(input int f, input int w, input int pw,
                                         input int len, input int gate);
    return {f[15:0], w[7:0], pw[7:0], len[7:0], gate[7:0]};
  endfunction

  // Note-level model: a queue of pending entries and, while playing, the
  // number of clocks since the load edge. A note lasts len*TD+1 clocks and the
  // gate is high for the first min(gate,len)*TD of them.
  logic [47:0] m_q[$];
  bit          m_play;
  int          m_t;
  int          m_period;
  int          m_gate_clks;
  logic [15:0] m_freq;
  logic [7:0]  m_pw;
  logic [7:0]  m_att;
  logic [7:0]  m_sus;
  logic [7:0]  m_wave;
  bit          m_under;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_play = 0; m_t = 0; m_period = 0; m_gate_clks = 0;
      m_freq = '0; m_pw = '0; m_att = '0; m_sus = '0; m_wave = '0; m_under = 0;
    end else begin
      bit do_push;
      bit can_pop;
      logic [47:0] e;
      int n;
      int g;
      do_push = wr_valid && (m_q.size() < DEPTH);
      can_pop = enable && (m_q.size() > 0);
      m_under = 0;
      if (m_play) begin
        m_t++;
        if (m_t == m_period) begin
          m_play  = 0;
          m_under = enable && !can_pop;
        end
      end
      if (!m_play && can_pop) begin
        e = m_q.pop_front();
        n = (e[15:8] == 8'd0) ? 256 : int'(e[15:8]);
        g = int'(e[7:0]);
        m_period    = n * TD + 1;
        m_gate_clks = ((g < n) ? g : n) * TD;
        m_freq = e[47:32];
        m_pw   = e[23:16];
        m_wave = e[31:24];
        m_att  = cfg_attack;
        m_sus  = cfg_sustain;
        m_t    = 0;
        m_play = 1;
      end
      if (do_push) m_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      bit g;
      g = m_play && (m_t < m_gate_clks);
      checkOutput("frequency", frequency, m_freq);
      checkOutput("duration", duration, m_pw);
      checkOutput("attack", attack, m_att);
      checkOutput("sustain", sustain, m_sus);
      checkOutput("waveform", waveform, {m_wave[7:1], g});
      checkOutput("busy", busy, m_play);
      checkOutput("fifo_count", fifo_count, m_q.size());
      checkOutput("wr_ready", wr_ready, m_q.size() < DEPTH);
      checkOutput("underrun", underrun, m_under);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [47:0] data, input logic valid, input logic en);
    wr_data  = data;
    wr_valid = valid;
    enable   = en;
    step();
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checkOutput("idle_timeout", busy, 0);
  endtask

  initial begin
    int on, off, und, rises, busyc, n;
    bit prev;
    logic [15:0] freqs [8];

    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; enable = 1'b0;
    cfg_attack = '0; cfg_sustain = '0;
    #1 rst = 1'b1;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: reset state
    step();
    checkOutput("t1_frequency", frequency, 0);
    checkOutput("t1_waveform", waveform, 0);
    checkOutput("t1_duration", duration, 0);
    checkOutput("t1_attack", attack, 0);
    checkOutput("t1_wr_ready", wr_ready, 1);
    checkOutput("t1_fifo_count", fifo_count, 0);
    checkOutput("t1_busy", busy, 0);

    // Test 2: single note, len=3 gate=2
    cfg_attack = 8'h5A; cfg_sustain = 8'hC3;
    applyStimulus(mkNote(148, 'h40, 'h80, 3, 2), 1'b1, 1'b1);
    checkOutput("t2_count_after_push", fifo_count, 1);
    checkOutput("t2_not_loaded_yet", waveform, 0);
    wr_valid = 1'b0;
    step();
    checkOutput("t2_loaded_wave", waveform, 'h41);
    checkOutput("t2_loaded_freq", frequency, 148);
    checkOutput("t2_loaded_pw", duration, 'h80);
    checkOutput("t2_loaded_attack", attack, 'h5A);
    checkOutput("t2_loaded_sustain", sustain, 'hC3);
    on = 0; off = 0; und = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy && waveform == 8'h41) on++;
      if (busy && waveform == 8'h40) off++;
      if (underrun) und++;
      step();
    end
    checkOutput("t2_gate_on_clks", on, 8);
    checkOutput("t2_gate_off_clks", off, 5);
    checkOutput("t2_underrun_pulses", und, 1);
    checkOutput("t2_idle_wave", waveform, 'h40);
    checkOutput("t2_idle_busy", busy, 0);

    // Test 3: fill while disabled, overflow dropped, play in order
    for (int i = 0; i < 8; i++) applyStimulus(mkNote(100 + i, 'h20, 'h10, 1, 1), 1'b1, 1'b0);
    wr_data = mkNote(108, 'h20, 'h10, 1, 1);
    checkOutput("t3_full_count", fifo_count, 8);
    checkOutput("t3_full_ready", wr_ready, 0);
    step();
    checkOutput("t3_drop_count", fifo_count, 8);
    enable = 1'b1;
    step();
    wr_valid = 1'b0;
    checkOutput("t3_pop_drop_count", fifo_count, 7);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (waveform[0] && !prev) begin
        if (rises < 8) freqs[rises] = frequency;
        rises++;
      end
      prev = waveform[0];
      step();
    end
    checkOutput("t3_note_count", rises, 8);
    for (int i = 0; i < 8; i++) checkOutput("t3_order", freqs[i], 100 + i);
    checkOutput("t3_empty", fifo_count, 0);

    // Test 4: back-to-back identical notes retrigger after one low clock
    applyStimulus(mkNote(500, 'h10, 'h40, 2, 5), 1'b1, 1'b1);
    applyStimulus(mkNote(500, 'h10, 'h40, 2, 5), 1'b1, 1'b1);
    wr_valid = 1'b0;
    n = 0;
    while (waveform[0] && n < 50) begin step(); n++; end
    checkOutput("t4_high_clks", n, 8);
    n = 0;
    while (!waveform[0] && n < 50) begin step(); n++; end
    checkOutput("t4_low_clks", n, 1);
    checkOutput("t4_retrigger", waveform[0], 1);
    waitIdle(100);

    // Test 5: rest note, host wave[0] ignored
    applyStimulus(mkNote(300, 'h81, 'h22, 2, 0), 1'b1, 1'b1);
    wr_valid = 1'b0;
    step();
    checkOutput("t5_freq", frequency, 300);
    checkOutput("t5_wave", waveform, 'h80);
    busyc = 0; on = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busyc++;
      if (waveform[0]) on++;
      step();
    end
    checkOutput("t5_busy_clks", busyc, 9);
    checkOutput("t5_gate_clks", on, 0);

    // Test 7: note_len=0 means 256 ticks, gate 255
    cfg_attack = 8'h11;
    applyStimulus(mkNote('h1234, 'h10, 'h01, 0, 255), 1'b1, 1'b1);
    wr_valid = 1'b0;
    step();
    checkOutput("t7_attack", attack, 'h11);
    cfg_attack = 8'h99;
    busyc = 0; on = 0;
    while (busy && busyc < 1100) begin
      busyc++;
      if (waveform[0]) on++;
      step();
    end
    checkOutput("t7_busy_clks", busyc, 1025);
    checkOutput("t7_gate_clks", on, 1020);
    checkOutput("t7_attack_held", attack, 'h11);

    // Test 6: asynchronous reset mid GATE_ON
    applyStimulus(mkNote(777, 'h20, 'h55, 4, 3), 1'b1, 1'b1);
    applyStimulus(mkNote(778, 'h20, 'h55, 4, 3), 1'b1, 1'b1);
    wr_valid = 1'b0;
    repeat (3) step();
    checkOutput("t6_pre_gate", waveform[0], 1);
    checkOutput("t6_pre_count", fifo_count, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_frequency", frequency, 0);
    checkOutput("t6_waveform", waveform, 0);
    checkOutput("t6_duration", duration, 0);
    checkOutput("t6_fifo_count", fifo_count, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_wr_ready", wr_ready, 1);
    step();
    rst = 1'b0;
    repeat (3) step();
    checkOutput("t6_after_busy", busy, 0);
    checkOutput("t6_after_count", fifo_count, 0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
